spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  Serial front end of the SPI wrapper; sits directly upstream of the SPI RAM.
//  Deserialises 10-bit command frames from MOSI into rx_data/rx_valid for the RAM.
//  For read-data commands, takes the RAM reply (tx_data/tx_valid) and shifts it out on MISO.
//  The SPI bit clock and the system clock are the same net (clk). Bits are sampled on posedge.
// PARAMETERS
//  FRAME_W  10  bits per command frame: {cmd[1:0], payload[7:0]}
//  DATA_W   8   bits returned on MISO per read-data command
// PORTS
//  clk       in   1        system/SPI clock; all logic on posedge
//  rst_n     in   1        asynchronous, active-low reset
//  SS_n      in   1        slave select, active low; high = idle / abort
//  MOSI      in   1        serial data in, MSB first
//  MISO      out  1        serial data out, MSB first; 0 when not transmitting
//  rx_data   out  FRAME_W  received frame to RAM (RAM din)
//  rx_valid  out  1        one-cycle strobe: rx_data valid
//  tx_data   in   DATA_W   read data from RAM (RAM dout)
//  tx_valid  in   1        RAM read data valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0, rd_addr_flag=0,
//   bit/tx counters=0. Reset mid-frame discards the frame; no rx_valid is issued.
//  All outputs are registered.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
//  CHK_CMD: this edge samples frame bit 9 (MOSI).
//   MOSI=0 -> WRITE. MOSI=1 & rd_addr_flag=0 -> READ_ADD. MOSI=1 & rd_addr_flag=1 -> READ_DATA.
//  WRITE / READ_ADD / READ_DATA: the next 9 edges sample bits 8..0 MSB first.
//   The edge that samples bit 0 loads rx_data={bits9..0} and sets rx_valid=1 for exactly 1 cycle.
//   Latency: SS_n low at edge 0; bit9 at edge 1; rx_valid high in the cycle after edge 10.
//  MOSI bits after the 10th bit of a frame are ignored; no second rx_valid until SS_n cycles high.
//  rd_addr_flag: set when a READ_ADD frame completes; cleared when a READ_DATA frame completes.
//   An aborted frame leaves the flag unchanged.
//  Cmd bits [9:8] are forwarded unchanged. The RAM decodes them; this block does not check them.
//  READ_DATA reply:
//   - tx_valid is ignored during the rx_valid cycle. From the next cycle on, the first edge with
//     tx_valid=1 captures tx_data and drives MISO=tx_data[7].
//   - The next 7 edges drive bits 6..0, then MISO=0. One reply per frame; later tx_valid ignored.
//  SS_n=1 in any non-IDLE state -> IDLE on the next edge.
//   Counters clear and MISO=0 (this aborts an in-progress reply).
//   A partial frame produces no rx_valid.
//  SS_n=1 on the same edge as bit 0 is sampled: the frame is aborted; no rx_valid is issued.
//  Bit counter uses ceil(log2(FRAME_W)) bits and never wraps within a frame.
//  The tx counter counts DATA_W bits.
// TESTING
//  1 WRITE addr: SS_n=0, shift 10'b00_0010_1010 -> rx_data=10'h02A, 1-cycle rx_valid after edge 10, flag=0, MISO=0
//  2 WRITE data: shift 10'b01_1111_0000 -> rx_data=10'h1F0, rx_valid 1 cycle; SS_n=1 -> IDLE
//  3 Read addr then read data:
//    - shift 10'h22A -> rx_data=10'h22A, flag=1.
//    - Next frame 10'h300 with RAM returning tx_data=8'hF0 (tx_valid 1 cycle after rx_valid)
//      -> MISO=1,1,1,1,0,0,0,0 on 8 consecutive cycles, then 0; flag=0.
//  4 Abort: SS_n=1 after 5 bits -> no rx_valid, IDLE next edge; the following 10'h055 frame is received correctly
//  5 Flag gating: MOSI bit9=1 with flag=0 -> enters READ_ADD (not READ_DATA); a stale tx_valid=1 produces no MISO activity
//  6 Reset mid-reply: rst_n=0 after 3 MISO bits -> MISO=0, rx_valid=0, flag=0 immediately; IDLE after release

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial front end of the SPI wrapper, directly upstream of the SPI RAM.
// Deserialises 10-bit command frames {cmd[1:0], payload[7:0]} from MOSI and hands them
// to the RAM as rx_data with a one-cycle rx_valid strobe. For read-data frames the RAM
// reply (tx_data/tx_valid) is shifted out on MISO, MSB first. SPI bit clock == clk.
//
// Ports:
//   clk       system/SPI clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   SS_n      slave select, active low; high aborts any frame or reply
//   MOSI      serial data in, MSB first
//   MISO      serial data out, MSB first; 0 when not transmitting
//   rx_data   received frame to RAM
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read data from RAM
//   tx_valid  RAM read data valid
module spi_slave_if #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int unsigned BitCntW = $clog2(FRAME_W);
  localparam int unsigned TxCntW  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StChkCmd   = 3'd1,
    StWrite    = 3'd2,
    StReadAdd  = 3'd3,
    StReadData = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0]   rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_flag_q, rd_addr_flag_d;
  logic [DATA_W-1:0]    tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0]    tx_cnt_q, tx_cnt_d;
  logic                 miso_q, miso_d;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;

    if (state_q != StIdle && SS_n) begin
      // Abort: a partial frame (even one whose last bit is on this edge) is dropped.
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          if (!SS_n) state_d = StChkCmd;
        end
        StChkCmd: begin
          rx_shift_d = {rx_shift_q[FRAME_W-3:0], MOSI};
          bit_cnt_d  = BitCntW'(1);
          if (!MOSI)               state_d = StWrite;
          else if (rd_addr_flag_q) state_d = StReadData;
          else                     state_d = StReadAdd;
        end
        StWrite, StReadAdd, StReadData: begin
          // Counter saturates at FRAME_W: trailing MOSI bits are ignored.
          if (bit_cnt_q != BitCntW'(FRAME_W)) begin
            rx_shift_d = {rx_shift_q[FRAME_W-3:0], MOSI};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitCntW'(FRAME_W - 1)) begin
              rx_data_d  = {rx_shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == StReadAdd)  rd_addr_flag_d = 1'b1;
              if (state_q == StReadData) rd_addr_flag_d = 1'b0;
            end
          end
          // Reply window opens the cycle after the rx_valid strobe. tx_cnt_q saturates at
          // DATA_W so only one reply is sent per frame.
          if (state_q == StReadData && bit_cnt_q == BitCntW'(FRAME_W) && !rx_valid_q) begin
            if (tx_cnt_q == '0) begin
              if (tx_valid) begin
                miso_d     = tx_data[DATA_W-1];
                tx_shift_d = {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt_d   = TxCntW'(1);
              end
            end else if (tx_cnt_q != TxCntW'(DATA_W)) begin
              miso_d     = tx_shift_q[DATA_W-1];
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              tx_cnt_d   = tx_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frames are driven bit by bit just after each posedge,
// outputs are sampled 1 time unit after the posedge.
module tb_spi_slave_if;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_cmp;
  int n_err;
  int rxv_seen;
  int miso_seen;

  localparam logic [31:0] StIdle     = 32'd0;
  localparam logic [31:0] StReadAdd  = 32'd3;
  localparam logic [31:0] StReadData = 32'd4;

  spi_slave_if #(
    .FRAME_W(10),
    .DATA_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n bits of f starting at index hi, going down; tally rx_valid and MISO highs.
  task automatic shift_bits(input logic [9:0] f, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = f[hi - i];
      tick();
      if (rx_valid) rxv_seen++;
      if (MISO) miso_seen++;
    end
  endtask

  task automatic start_frame();
    SS_n = 1'b0;
    rxv_seen  = 0;
    miso_seen = 0;
    tick();
  endtask

  task automatic end_frame();
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tick();
  endtask

  logic [7:0] tx_byte;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // Reset state
    #3;
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h000);
    check("rst_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    check("rst_state", 32'(dut.state_q), StIdle);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: write address frame, then trailing bits must be ignored
    start_frame();
    shift_bits(10'b00_0010_1010, 9, 10);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h02A);
    tick();
    check("t1_rx_valid_pulse", 32'(rx_valid), 32'd0);
    check("t1_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    check("t1_miso", 32'(MISO), 32'd0);
    rxv_seen = 0;
    shift_bits(10'h3FF, 9, 3);
    check("t1_no_second_valid", 32'(rxv_seen), 32'd0);
    check("t1_rx_data_hold", 32'(rx_data), 32'h02A);
    end_frame();

    // 2: write data frame, SS_n high returns to IDLE
    start_frame();
    shift_bits(10'b01_1111_0000, 9, 10);
    check("t2_rx_data", 32'(rx_data), 32'h1F0);
    check("t2_rx_valid_cnt", 32'(rxv_seen), 32'd1);
    end_frame();
    check("t2_idle", 32'(dut.state_q), StIdle);
    check("t2_rx_valid_low", 32'(rx_valid), 32'd0);

    // 3: read address, then read data with an 8-bit reply
    start_frame();
    shift_bits(10'h22A, 9, 10);
    check("t3_rx_data_addr", 32'(rx_data), 32'h22A);
    check("t3_flag_set", 32'(dut.rd_addr_flag_q), 32'd1);
    end_frame();
    start_frame();
    shift_bits(10'h300, 9, 1);
    check("t3_state_rd_data", 32'(dut.state_q), StReadData);
    shift_bits(10'h300, 8, 9);
    check("t3_rx_data_rd", 32'(rx_data), 32'h300);
    check("t3_rx_valid_cnt", 32'(rxv_seen), 32'd1);
    check("t3_flag_clr", 32'(dut.rd_addr_flag_q), 32'd0);
    // tx_valid during the rx_valid cycle must not start a reply
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    tick();
    check("t3_ignore_in_rxv_cycle", 32'(MISO), 32'd0);
    tx_byte  = 8'hF0;
    tx_data  = tx_byte;
    for (int i = 0; i < 8; i++) begin
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check($sformatf("t3_miso_bit%0d", 7 - i), 32'(MISO), 32'(tx_byte[7 - i]));
    end
    tick();
    check("t3_miso_after", 32'(MISO), 32'd0);
    tx_data   = 8'hFF;
    tx_valid  = 1'b1;
    miso_seen = 0;
    shift_bits(10'h000, 9, 4);
    check("t3_one_reply", 32'(miso_seen), 32'd0);
    end_frame();

    // 4: abort after 5 bits of a read-address frame, then a clean frame
    start_frame();
    shift_bits(10'h255, 9, 5);
    end_frame();
    check("t4_abort_idle", 32'(dut.state_q), StIdle);
    check("t4_abort_no_valid", 32'(rxv_seen + 32'(rx_valid)), 32'd0);
    check("t4_abort_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    start_frame();
    shift_bits(10'h055, 9, 10);
    check("t4_rx_data", 32'(rx_data), 32'h055);
    check("t4_rx_valid_cnt", 32'(rxv_seen), 32'd1);
    end_frame();

    // 5: bit9=1 with flag clear goes to READ_ADD; stale tx_valid gives no MISO activity
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    start_frame();
    shift_bits(10'h2C3, 9, 1);
    check("t5_state_rd_add", 32'(dut.state_q), StReadAdd);
    shift_bits(10'h2C3, 8, 9);
    check("t5_rx_data", 32'(rx_data), 32'h2C3);
    shift_bits(10'h000, 9, 4);
    check("t5_no_miso", 32'(miso_seen), 32'd0);
    check("t5_flag_set", 32'(dut.rd_addr_flag_q), 32'd1);
    end_frame();

    // 6: reset in the middle of a reply
    start_frame();
    shift_bits(10'h3A5, 9, 10);
    check("t6_rx_data", 32'(rx_data), 32'h3A5);
    tick();
    tx_byte  = 8'hB7;
    tx_data  = tx_byte;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tx_valid = 1'b0;
      check($sformatf("t6_miso_bit%0d", 7 - i), 32'(MISO), 32'(tx_byte[7 - i]));
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso", 32'(MISO), 32'd0);
    check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    tick();
    rst_n = 1'b1;
    SS_n  = 1'b1;
    tick();
    check("t6_idle", 32'(dut.state_q), StIdle);
    check("t6_miso_idle", 32'(MISO), 32'd0);

    // 7: SS_n rises on the same edge as bit 0 -> no rx_valid
    start_frame();
    shift_bits(10'h1C6, 9, 9);
    MOSI = 1'b0;
    SS_n = 1'b1;
    tick();
    check("t7_no_valid", 32'(rx_valid), 32'd0);
    check("t7_idle", 32'(dut.state_q), StIdle);
    tick();
    check("t7_no_valid_late", 32'(rxv_seen + 32'(rx_valid)), 32'd0);
    check("t7_rx_data_hold", 32'(rx_data), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
